// File: rtl/svn_seg_scan.sv
// rtl/svn_seg_scan.sv - scan controller for a multiplexed common-anode seven-segment display
module svn_seg_scan #(
    parameter int NDIG  = 4,
    parameter int DWELL = 1000,
    parameter int GUARD = 2
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [4*NDIG-1:0] i_digits,
    input  logic              i_load,
    input  logic              i_lzb,
    output logic [3:0]        o_d,
    output logic [NDIG-1:0]   o_an,
    output logic              o_pending,
    output logic              o_frame
);
    localparam int MAXC = (DWELL > GUARD) ? DWELL : GUARD;
    localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
    localparam int IW   = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [CW-1:0] C_DWELL = CW'(DWELL - 1);
    localparam logic [CW-1:0] C_GUARD = CW'(GUARD - 1);
    localparam logic [IW-1:0] C_LAST  = IW'(NDIG - 1);

    typedef enum logic {S_GUARD, S_DRIVE} state_t;

    state_t              r_state;
    logic [4*NDIG-1:0]   r_pend;
    logic [4*NDIG-1:0]   r_disp;
    logic [IW-1:0]       r_idx;
    logic [CW-1:0]       r_cnt;
    logic [3:0]          r_d;
    logic [NDIG-1:0]     r_an;
    logic                r_pending;
    logic                r_frame;

    state_t              w_state_nxt;
    logic [4*NDIG-1:0]   w_pend_nxt;
    logic [4*NDIG-1:0]   w_disp_nxt;
    logic [IW-1:0]       w_idx_nxt;
    logic [CW-1:0]       w_cnt_nxt;
    logic [3:0]          w_d_nxt;
    logic [NDIG-1:0]     w_an_nxt;
    logic                w_pending_nxt;
    logic                w_wrap;
    logic [NDIG-1:0]     w_blank;

    // Digit k>0 is blanked when it and every more significant nibble are zero.
    always_comb begin
        w_blank = '0;
        for (int k = 1; k < NDIG; k++) begin
            w_blank[k] = i_lzb && ((r_disp >> (4 * k)) == '0);
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_pend_nxt    = r_pend;
        w_disp_nxt    = r_disp;
        w_idx_nxt     = r_idx;
        w_cnt_nxt     = r_cnt - 1'b1;
        w_d_nxt       = r_d;
        w_an_nxt      = '1;
        w_pending_nxt = r_pending;
        w_wrap        = 1'b0;

        if (i_load) begin
            w_pend_nxt    = i_digits;
            w_pending_nxt = 1'b1;
        end

        case (r_state)
            S_GUARD: begin
                if (r_cnt == '0) begin
                    w_state_nxt = S_DRIVE;
                    w_cnt_nxt   = C_DWELL;
                    if (!w_blank[r_idx]) w_an_nxt[r_idx] = 1'b0;
                end
            end
            S_DRIVE: begin
                if (r_cnt == '0) begin
                    w_state_nxt = S_GUARD;
                    w_cnt_nxt   = C_GUARD;
                    w_idx_nxt   = (r_idx == C_LAST) ? '0 : r_idx + 1'b1;
                    if (r_idx == C_LAST) begin
                        // Frame boundary: a LOAD in this very cycle bypasses the pending slot.
                        w_wrap = 1'b1;
                        if (i_load) begin
                            w_disp_nxt    = i_digits;
                            w_pending_nxt = 1'b0;
                        end else if (r_pending) begin
                            w_disp_nxt    = r_pend;
                            w_pending_nxt = 1'b0;
                        end
                    end
                    w_d_nxt = w_disp_nxt[4*w_idx_nxt +: 4];
                end else if (!w_blank[r_idx]) begin
                    w_an_nxt[r_idx] = 1'b0;
                end
            end
            default: w_state_nxt = S_GUARD;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state   <= S_GUARD;
            r_pend    <= '0;
            r_disp    <= '0;
            r_idx     <= '0;
            r_cnt     <= C_GUARD;
            r_d       <= '0;
            r_an      <= '1;
            r_pending <= 1'b0;
            r_frame   <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_pend    <= w_pend_nxt;
            r_disp    <= w_disp_nxt;
            r_idx     <= w_idx_nxt;
            r_cnt     <= w_cnt_nxt;
            r_d       <= w_d_nxt;
            r_an      <= w_an_nxt;
            r_pending <= w_pending_nxt;
            r_frame   <= w_wrap;
        end
    end

    assign o_d       = r_d;
    assign o_an      = r_an;
    assign o_pending = r_pending;
    assign o_frame   = r_frame;
endmodule

// File: tb/tb_svn_seg_scan.sv
// tb/tb_svn_seg_scan.sv - self-checking bench for svn_seg_scan
module tb_svn_seg_scan;
    localparam int NDIG  = 4;
    localparam int DWELL = 4;
    localparam int GUARD = 2;
    localparam int DIGP  = GUARD + DWELL;
    localparam int FLEN  = NDIG * DIGP;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] digits = '0;
    logic        load = 1'b0;
    logic        lzb = 1'b0;
    logic [3:0]  d;
    logic [3:0]  an;
    logic        pending;
    logic        frame;

    svn_seg_scan #(.NDIG(NDIG), .DWELL(DWELL), .GUARD(GUARD)) dut (
        .i_clk(clk), .i_rst(rst), .i_digits(digits), .i_load(load), .i_lzb(lzb),
        .o_d(d), .o_an(an), .o_pending(pending), .o_frame(frame)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: position in the frame follows from elapsed cycles since reset.
    int          t = 0;
    logic [15:0] m_disp = '0;
    logic [15:0] m_pend = '0;
    logic        m_pending = 1'b0;
    logic [3:0]  g_prev_d = '0;
    logic [3:0]  g_prev_an = 4'hF;
    int          g_run = 0;

    typedef struct {
        logic [15:0] dg;
        logic        lz;
        logic [3:0]  low_mask;
    } blank_vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0d)", name, act, exp, t);
        end
    endtask

    task automatic check_model(input logic lz);
        int p, dig, ph;
        logic [3:0] an_exp;
        logic [15:0] sh;
        p      = t % FLEN;
        dig    = p / DIGP;
        ph     = p % DIGP;
        an_exp = 4'hF;
        sh     = m_disp >> (4 * dig);
        if (ph >= GUARD && !(lz && dig > 0 && sh == 16'h0)) an_exp[dig] = 1'b0;
        chk("an", {28'h0, an}, {28'h0, an_exp});
        chk("d", {28'h0, d}, {28'h0, sh[3:0]});
        chk("frame", {31'h0, frame}, {31'h0, (t > 0 && p == 0)});
        chk("pending", {31'h0, pending}, {31'h0, m_pending});
    endtask

    task automatic ghost_check();
        logic ones;
        ones = (an == 4'hF);
        chk("ghost_onehot", {31'h0, ($countones(~an) <= 1)}, 32'h1);
        if (d != g_prev_d) begin
            chk("ghost_d_change_dark", {31'h0, ones}, 32'h1);
            g_run = ones ? 1 : 0;
        end else if (ones) begin
            g_run++;
        end else begin
            if (g_prev_an == 4'hF) chk("ghost_guard", {31'h0, (g_run >= GUARD)}, 32'h1);
            g_run = 0;
        end
        g_prev_d  = d;
        g_prev_an = an;
    endtask

    task automatic tick(input logic ld, input logic [15:0] dg, input logic lz);
        load = ld; digits = dg; lzb = lz;
        @(posedge clk);
        #1;
        load = 1'b0;
        t++;
        if (t % FLEN == 0) begin
            if (ld) m_disp = dg;
            else if (m_pending) m_disp = m_pend;
            if (ld) m_pend = dg;
            m_pending = 1'b0;
        end else if (ld) begin
            m_pend = dg;
            m_pending = 1'b1;
        end
        check_model(lz);
        ghost_check();
    endtask

    task automatic advance_to(input int p, input logic lz);
        tick(1'b0, 16'h0, lz);
        while (t % FLEN != p) tick(1'b0, 16'h0, lz);
    endtask

    task automatic run_frame(input logic lz, output logic [15:0] dseq, output logic [3:0] low);
        dseq = '0;
        low  = '0;
        for (int i = 0; i < FLEN; i++) begin
            tick(1'b0, 16'h0, lz);
            low = low | ~an;
            if ((t % FLEN) % DIGP == GUARD + 1) dseq[4*((t % FLEN) / DIGP) +: 4] = d;
        end
    endtask

    task automatic apply_reset_async();
        #2 rst = 1'b1;
        #1;
        chk("rst_an_immediate", {28'h0, an}, 32'hF);
        chk("rst_pending_immediate", {31'h0, pending}, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        t = 0; m_disp = '0; m_pend = '0; m_pending = 1'b0;
        g_prev_d = 4'h0; g_prev_an = 4'hF; g_run = 1;
        check_model(1'b0);
    endtask

    initial begin
        blank_vec_t bv[9];
        logic [15:0] dseq;
        logic [3:0]  low;
        int first_frame;

        bv[0] = '{16'h0070, 1'b1, 4'b0011};
        bv[1] = '{16'h0000, 1'b1, 4'b0001};
        bv[2] = '{16'h0070, 1'b0, 4'b1111};
        bv[3] = '{16'h0000, 1'b0, 4'b1111};
        bv[4] = '{16'h1000, 1'b1, 4'b1111};
        bv[5] = '{16'h00A0, 1'b1, 4'b0011};
        bv[6] = '{16'h0100, 1'b1, 4'b0111};
        bv[7] = '{16'hF000, 1'b1, 4'b1111};
        bv[8] = '{16'h0001, 1'b1, 4'b0001};

        // Reset and first frame
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        g_run = 1;
        check_model(1'b0);
        first_frame = -1;
        for (int i = 0; i < 30; i++) begin
            tick(1'b0, 16'h0, 1'b0);
            if (frame && first_frame < 0) first_frame = t;
        end
        chk("first_frame_cycle", first_frame, 24);

        // Load commit
        advance_to(9, 1'b0);
        tick(1'b1, 16'h1234, 1'b0);
        chk("load_pending", {31'h0, pending}, 32'h1);
        advance_to(0, 1'b0);
        chk("load_frame_pulse", {31'h0, frame}, 32'h1);
        run_frame(1'b0, dseq, low);
        chk("load_dseq", {16'h0, dseq}, 32'h1234);

        // Double load, last write wins
        advance_to(5, 1'b0);
        tick(1'b1, 16'h1111, 1'b0);
        advance_to(15, 1'b0);
        tick(1'b1, 16'h2222, 1'b0);
        advance_to(0, 1'b0);
        run_frame(1'b0, dseq, low);
        chk("double_load_dseq", {16'h0, dseq}, 32'h2222);

        // Bypass: LOAD in the commit cycle beats a pending value
        advance_to(3, 1'b0);
        tick(1'b1, 16'h7777, 1'b0);
        advance_to(23, 1'b0);
        tick(1'b1, 16'h5555, 1'b0);
        chk("bypass_d", {28'h0, d}, 32'h5);
        chk("bypass_pending", {31'h0, pending}, 32'h0);
        chk("bypass_frame", {31'h0, frame}, 32'h1);
        run_frame(1'b0, dseq, low);
        chk("bypass_dseq", {16'h0, dseq}, 32'h5555);

        // Leading-zero blanking table
        foreach (bv[i]) begin
            advance_to(10, bv[i].lz);
            tick(1'b1, bv[i].dg, bv[i].lz);
            advance_to(0, bv[i].lz);
            run_frame(bv[i].lz, dseq, low);
            chk("blank_low_mask", {28'h0, low}, {28'h0, bv[i].low_mask});
            chk("blank_dseq", {16'h0, dseq}, {16'h0, bv[i].dg});
        end

        // Async reset mid-DRIVE of digit 2 with a load pending
        advance_to(0, 1'b0);
        tick(1'b1, 16'h4321, 1'b0);
        advance_to(0, 1'b0);
        advance_to(4, 1'b0);
        tick(1'b1, 16'h9876, 1'b0);
        advance_to(14, 1'b0);
        chk("pre_rst_an", {28'h0, an}, 32'hB);
        chk("pre_rst_pending", {31'h0, pending}, 32'h1);
        apply_reset_async();
        run_frame(1'b0, dseq, low);
        chk("post_rst_dseq", {16'h0, dseq}, 32'h0);

        // Random frames with random loads
        for (int i = 0; i < 10 * FLEN; i++) begin
            logic ld;
            logic rl;
            rl = (t % FLEN == 0) ? 1'($urandom_range(0, 1)) : lzb;
            ld = ($urandom_range(0, 15) == 0);
            tick(ld, 16'($urandom), rl);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end
endmodule

// File: doc/svn_seg_scan.md
# svn_seg_scan

Time-multiplexed scan controller for a multi-digit common-anode seven-segment display, driving one shared `svn_seg` decoder. It holds a double-buffered BCD word and presents one digit nibble at a time on `D`. After a guard interval that covers the decoder's one-cycle registered latency and prevents ghosting, it enables that digit's anode. It sits between the lightning-detector status/count logic, which produces the value, and the board display pins.

## Interface
- `NDIG`, default 4: number of digits, 1..8.
- `DWELL`, default 1000: cycles each digit's anode is on, at least 1.
- `GUARD`, default 2: cycles all anodes are off before each digit, at least 1.
- `CLK`  in  1: single clock; all state changes on the rising edge.
- `RST`  in  1: reset, asynchronous, active-high.
- `DIGITS`  in  4*NDIG: new BCD value; nibble k is digit k, with digit 0 as the least significant (rightmost).
- `LOAD`  in  1: one-cycle strobe that captures `DIGITS` into the pending register.
- `LZB`  in  1: leading-zero blanking enable; sampled every cycle.
- `D`  out  4: nibble to the `svn_seg` D input; registered.
- `AN`  out  NDIG: anode enables, active-low; registered.
- `PENDING`  out  1: a loaded value is waiting for the next frame boundary.
- `FRAME`  out  1: one-cycle pulse on each commit, i.e. at the start of every frame.

## Operation
- **Registers**
  - `pend`: 4*NDIG bits, the pending value.
  - `disp`: 4*NDIG bits, the displayed value.
  - `idx`: digit index, 0..NDIG-1.
  - `cnt`: down-counter, sized by $clog2 of max(DWELL, GUARD).
  - `state`: GUARD or DRIVE.
- **Reset values**
  - `pend`=0, `disp`=0, `idx`=0, `state`=GUARD, `cnt`=GUARD-1.
  - Outputs: `D`=0, `AN`=all ones, `PENDING`=0, `FRAME`=0.
- **LOAD**
  - `pend` <= `DIGITS` and `PENDING` <= 1.
  - A later LOAD before commit overwrites `pend`; last write wins.
- **GUARD state**
  - `AN` = all ones.
  - When `cnt`=0: go to DRIVE, `cnt` <= DWELL-1.
  - Otherwise `cnt` decrements.
- **DRIVE state**
  - `AN[idx]`=0 unless digit idx is blanked; all other bits are 1.
  - When `cnt`=0: go to GUARD, `cnt` <= GUARD-1, `idx` <= idx+1, wrapping NDIG-1 -> 0.
  - `D` <= `disp` nibble for the new idx, loaded on the same edge.
- **Commit (frame boundary)**
  - Occurs on the DRIVE->GUARD edge where idx wraps to 0. It does not occur on the first frame after reset.
  - If `PENDING`=1: `disp` <= `pend`, `PENDING` <= 0.
  - If `LOAD` is high in the commit cycle: `disp` <= `DIGITS` directly (bypass), and `PENDING` stays 0.
  - `D` uses the newly committed digit 0.
  - `FRAME` is pulsed on every wrap, even when nothing was committed.
- **Blanking**
  - With `LZB`=1, digit k>0 is blanked when every nibble k..NDIG-1 of `disp` is 0.
  - Digit 0 is never blanked, so 0 displays as a single "0".
  - A blanked digit still consumes its DWELL time, so scan timing stays fixed.
- **Non-BCD nibbles (A..F)**
  - Passed through unchanged to `D`; the decoder renders them as its default pattern.
  - Not treated as zero for blanking.

## Timing
- Per digit: GUARD + DWELL cycles. Frame: NDIG*(GUARD+DWELL) cycles.
- `D` changes on the first GUARD cycle of each digit. Decoder `SEG` is valid one cycle later.
- The anode asserts GUARD cycles after `D` changes, so GUARD>=1 guarantees `SEG` is stable before the anode is on.
- `D` is constant throughout GUARD and DRIVE of a digit.
- At most one `AN` bit is low at any time.
- There is at least one all-ones `AN` cycle between any two different digits, including the wrap and the NDIG=1 case.
- LOAD-to-display latency: up to one frame plus GUARD cycles. Displayed digits never change mid-frame.
- RST asserted mid-frame:
  - Immediately: `AN`=all ones and `PENDING`=0; any pending value is lost.
  - After release: scanning restarts at digit 0 in GUARD, showing 0.

## Test plan
NDIG=4, DWELL=4, GUARD=2 unless noted.
- **Reset and first frame.** Release RST and observe `AN` and `D`.
  - `AN`=1111 for 2 cycles, then 1110 for 4 cycles, then 1111 for 2, then 1101, and so on.
  - `D`=0 throughout; first `FRAME` pulse at cycle 24.
- **Load commit.** LOAD with `DIGITS`=16'h1234 at mid-digit 1.
  - `PENDING`=1 until the wrap; `FRAME` pulses at the wrap.
  - Next frame: `D` sequence is 4,3,2,1, with each anode low only after its guard.
- **Double load and bypass.** LOAD 16'h1111 mid-frame, then 16'h2222; commit shows 2222.
  - Separately, LOAD 16'h5555 exactly in the commit cycle: digit 0 of that frame shows 5 and `PENDING` stays 0.
- **Leading-zero blanking.** `LZB`=1, `DIGITS`=16'h0070.
  - `AN` digits 3 and 2 are never low; digits 1 and 0 are low.
  - With 16'h0000, only digit 0 is low.
  - With `LZB`=0, all four digits are low in turn.
- **Async reset mid-DRIVE.** Assert RST while `AN`=1011 with `PENDING`=1.
  - `AN`=1111 and `PENDING`=0 before the next clock edge; `disp`=0 after release.
- **Ghost check.** Over 10 random frames with random LOADs, assert:
  - Never more than one `AN` bit low.
  - `D` never changes while any `AN` bit is low.
  - Each anode-low window is preceded by at least 2 all-ones cycles (GUARD=2) after `D` last changed.
